wave_shaper_mc: RTL and testbench

- Multi-channel, time-multiplexed oscillator and waveshaper for the synth voice path.
- Holds one phase accumulator per channel and turns each phase into saw, triangle, pulse or reverse-saw output at WIDTH bits.
- Each sample_tick starts one frame that services every channel in order; results stream out as (out_chan, out_data, out_valid) to the mixer.
- Adds per-channel frequency, mode and shape registers, hard sync, and overrun detection.

---
 rtl/wave_shaper_mc_if.sv | 41 ++++
 rtl/wave_shaper_mc.sv | 180 ++++++++++++++++++
 tb/tb_wave_shaper_mc.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_shaper_mc_if.sv
// Bus bundle for wave_shaper_mc: register writes, frame control and the
// shaped sample stream toward the mixer.
interface wave_shaper_mc_if #(
  parameter int WIDTH     = 12,
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 24,
  parameter int CW        = $clog2(CHANNELS)
);
  logic                 sample_tick;
  logic                 freq_wr_en;
  logic [CW-1:0]        freq_wr_chan;
  logic [ACC_WIDTH-1:0] freq_wr_data;
  logic                 cfg_wr_en;
  logic [CW-1:0]        cfg_wr_chan;
  logic [1:0]           cfg_wr_mode;
  logic [WIDTH-1:0]     cfg_wr_shape;
  logic [CHANNELS-1:0]  sync_in;
  logic                 overrun_clr;
  logic                 out_valid;
  logic [CW-1:0]        out_chan;
  logic [WIDTH-1:0]     out_data;
  logic                 busy;
  logic                 overrun;
  logic [1:0]           dbg_state;

  // out_valid is a one-way strobe: the mixer has no ready and must take
  // out_chan/out_data in the cycle out_valid is high.
  modport master (
    output sample_tick, freq_wr_en, freq_wr_chan, freq_wr_data,
           cfg_wr_en, cfg_wr_chan, cfg_wr_mode, cfg_wr_shape,
           sync_in, overrun_clr,
    input  out_valid, out_chan, out_data, busy, overrun, dbg_state
  );

  modport slave (
    input  sample_tick, freq_wr_en, freq_wr_chan, freq_wr_data,
           cfg_wr_en, cfg_wr_chan, cfg_wr_mode, cfg_wr_shape,
           sync_in, overrun_clr,
    output out_valid, out_chan, out_data, busy, overrun, dbg_state
  );
endinterface

// File: rtl/wave_shaper_mc.sv
// Time-multiplexed multi-channel oscillator: one phase accumulator per channel,
// serviced once per sample_tick frame and shaped into saw/tri/pulse/rev-saw.
module wave_shaper_mc #(
  parameter int WIDTH     = 12,
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 24,
  parameter int CW        = $clog2(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst,
  wave_shaper_mc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] chan, chan_nxt;
  logic          drain_cnt, drain_cnt_nxt;
  logic          scan;

  logic [ACC_WIDTH-1:0] acc   [CHANNELS];
  logic [ACC_WIDTH-1:0] freq  [CHANNELS];
  logic [1:0]           mode  [CHANNELS];
  logic [WIDTH-1:0]     shape [CHANNELS];
  logic [CHANNELS-1:0]  sync_pend;
  logic                 sync_now;
  logic [CHANNELS-1:0]  sync_applied;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_p;
  logic [1:0]           s1_mode;
  logic [WIDTH-1:0]     s1_shape;
  logic [CW-1:0]        s1_chan;
  logic [WIDTH-1:0]     fold;
  logic [WIDTH-1:0]     shaped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      chan      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      chan      <= chan_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // A tick outside IDLE never restarts the frame; it only raises overrun.
  always_comb begin
    state_nxt     = state;
    chan_nxt      = chan;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (bus.sample_tick) begin
          state_nxt = SCAN;
          chan_nxt  = '0;
        end
      end
      SCAN: begin
        if (chan == LAST_CHAN) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 1'b0;
        end else begin
          chan_nxt = chan + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = IDLE;
        else           drain_cnt_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign scan          = (state == SCAN);
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

  // A sync pulse landing in the channel's own slot is honoured at once.
  assign sync_now     = scan && (sync_pend[chan] || bus.sync_in[chan]);
  assign sync_applied = scan ? (CHANNELS'(1) << chan) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pend <= '0;
    end else begin
      sync_pend <= (sync_pend | bus.sync_in) & ~sync_applied;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]  <= '0;
        freq[i] <= '0;
      end
    end else begin
      if (scan) acc[chan] <= sync_now ? '0 : acc[chan] + freq[chan];
      if (bus.freq_wr_en) freq[bus.freq_wr_chan] <= bus.freq_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]  <= 2'd0;
        shape[i] <= {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else if (bus.cfg_wr_en) begin
      mode[bus.cfg_wr_chan]  <= bus.cfg_wr_mode;
      shape[bus.cfg_wr_chan] <= bus.cfg_wr_shape;
    end
  end

  // Stage 1 captures the pre-update phase together with the channel's config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_mode  <= 2'd0;
      s1_shape <= '0;
      s1_chan  <= '0;
    end else begin
      s1_valid <= scan;
      if (scan) begin
        s1_p     <= acc[chan][ACC_WIDTH-1 -: WIDTH];
        s1_mode  <= mode[chan];
        s1_shape <= shape[chan];
        s1_chan  <= chan;
      end
    end
  end

  assign fold = {s1_p[WIDTH-2:0], 1'b0};

  always_comb begin
    shaped = s1_p;
    case (s1_mode)
      2'd0: shaped = s1_p;
      2'd1: shaped = s1_p[WIDTH-1] ? ~fold : fold;
      2'd2: shaped = (s1_p < s1_shape) ? '1 : '0;
      2'd3: shaped = ~s1_p;
      default: shaped = s1_p;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_chan <= s1_chan;
        bus.out_data <= shaped;
      end
    end
  end

  // A new overrun event wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.overrun <= 1'b0;
    end else if (bus.sample_tick && (state != IDLE)) begin
      bus.overrun <= 1'b1;
    end else if (bus.overrun_clr) begin
      bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_shaper_mc.sv
// Directed bench for wave_shaper_mc: frame timing, all four shapes, sync,
// register-write ordering, overrun and reset behaviour.
module tb_wave_shaper_mc;

  localparam int WIDTH     = 12;
  localparam int CHANNELS  = 4;
  localparam int ACC_WIDTH = 24;
  localparam int CW        = 2;

  logic clk;
  logic rst;

  wave_shaper_mc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ACC_WIDTH(ACC_WIDTH), .CW(CW)) bus ();

  wave_shaper_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ACC_WIDTH(ACC_WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_data;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic wr_freq(input logic [CW-1:0] ch, input logic [ACC_WIDTH-1:0] d);
    bus.freq_wr_en   = 1'b1;
    bus.freq_wr_chan = ch;
    bus.freq_wr_data = d;
    step();
    bus.freq_wr_en   = 1'b0;
  endtask

  task automatic wr_cfg(input logic [CW-1:0] ch, input logic [1:0] m, input logic [WIDTH-1:0] s);
    bus.cfg_wr_en    = 1'b1;
    bus.cfg_wr_chan  = ch;
    bus.cfg_wr_mode  = m;
    bus.cfg_wr_shape = s;
    step();
    bus.cfg_wr_en    = 1'b0;
  endtask

  task automatic push4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  // One full frame: tick at cycle T, then cycles T+1..T+8 with optional
  // pulses injected at cycle T+k and per-cycle timing/data checks.
  task automatic run_frame(input int sync_k, input logic [CHANNELS-1:0] sync_v,
                           input int tick_k, input int clr_k,
                           input int fw_k, input logic [CW-1:0] fw_ch,
                           input logic [ACC_WIDTH-1:0] fw_d);
    logic [WIDTH-1:0] e;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == sync_k) bus.sync_in = sync_v;
      if (k == tick_k) bus.sample_tick = 1'b1;
      if (k == clr_k)  bus.overrun_clr = 1'b1;
      if (k == fw_k) begin
        bus.freq_wr_en   = 1'b1;
        bus.freq_wr_chan = fw_ch;
        bus.freq_wr_data = fw_d;
      end
      check("busy", 32'(bus.busy), 32'(k <= 6));
      check("out_valid", 32'(bus.out_valid), 32'(k >= 3 && k <= 6));
      if (k == 1) check("state_scan", 32'(bus.dbg_state), 32'd1);
      if (k == 5) check("state_drain", 32'(bus.dbg_state), 32'd2);
      if (k == 7) check("state_idle", 32'(bus.dbg_state), 32'd0);
      if (tick_k > 0 && k == tick_k + 1) check("overrun_set", 32'(bus.overrun), 32'd1);
      if (k >= 3 && k <= 6 && bus.out_valid) begin
        check("out_chan", 32'(bus.out_chan), 32'(k - 3));
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out_data_ch%0d", k - 3), 32'(bus.out_data), 32'(e));
          last_data = e;
        end
      end
      if (k == 7) begin
        check("hold_chan", 32'(bus.out_chan), 32'd3);
        check("hold_data", 32'(bus.out_data), 32'(last_data));
      end
      step();
      bus.sample_tick = 1'b0;
      bus.overrun_clr = 1'b0;
      bus.sync_in     = '0;
      bus.freq_wr_en  = 1'b0;
    end
  endtask

  task automatic frame();
    run_frame(0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic clear_overrun();
    bus.overrun_clr = 1'b1;
    step();
    bus.overrun_clr = 1'b0;
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
  endtask

  logic [WIDTH-1:0] tri_tab[16];

  initial begin
    tri_tab = '{12'd0, 12'd512, 12'd1024, 12'd1536, 12'd2048, 12'd2560, 12'd3072, 12'd3584,
                12'd4095, 12'd3583, 12'd3071, 12'd2559, 12'd2047, 12'd1535, 12'd1023, 12'd511};
    last_data        = '0;
    rst              = 1'b0;
    bus.sample_tick  = 1'b0;
    bus.freq_wr_en   = 1'b0;
    bus.freq_wr_chan = '0;
    bus.freq_wr_data = '0;
    bus.cfg_wr_en    = 1'b0;
    bus.cfg_wr_chan  = '0;
    bus.cfg_wr_mode  = '0;
    bus.cfg_wr_shape = '0;
    bus.sync_in      = '0;
    bus.overrun_clr  = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_chan", 32'(bus.out_chan), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b1;
    step();

    // all-zero frame straight out of reset
    push4(0, 0, 0, 0);
    frame();

    // triangle / pulse / saw / saw sweeps across 16 frames
    wr_cfg(0, 2'd1, 12'h800);
    wr_freq(0, 24'h100000);
    wr_cfg(1, 2'd2, 12'h400);
    wr_freq(1, 24'h100000);
    wr_freq(2, 24'h800000);
    wr_freq(3, 24'h100000);
    for (int g = 0; g < 16; g++) begin
      push4(tri_tab[g], (g < 4) ? 12'd4095 : 12'd0, (g % 2 == 1) ? 12'd2048 : 12'd0, 12'(g * 256));
      frame();
    end

    // ch3 steps to phase 0xC00; pulse pattern repeats on ch1
    wr_freq(3, 24'h400000);
    push4(0, 4095, 0, 0);       frame();
    push4(512, 4095, 2048, 1024); frame();
    push4(1024, 4095, 0, 2048);   frame();

    // ch2 reverse saw; mid-frame sync on ch3 ahead of its slot
    wr_cfg(2, 2'd3, 12'h800);
    push4(1536, 4095, 2047, 3072);
    run_frame(2, 4'b1000, 0, 0, 0, '0, '0);
    push4(2048, 0, 4095, 0);    frame();
    push4(2560, 0, 2047, 1024); frame();

    // sync while idle takes effect in the next frame's update
    bus.sync_in = 4'b1000;
    step();
    bus.sync_in = '0;
    step();
    push4(3072, 0, 4095, 2048); frame();
    push4(3584, 0, 2047, 0);    frame();

    // freq write in ch0's slot plus a tick while busy
    push4(4095, 0, 4095, 1024);
    run_frame(0, '0, 2, 0, 1, 2'd0, 24'h200000);
    check("overrun_sticky", 32'(bus.overrun), 32'd1);
    clear_overrun();

    // overrun event and clear in the same cycle: event wins
    push4(3583, 0, 2047, 2048);
    run_frame(0, '0, 2, 2, 0, '0, '0);
    check("overrun_beats_clr", 32'(bus.overrun), 32'd1);
    clear_overrun();
    push4(2559, 0, 4095, 3072); frame();

    // reset in the middle of a frame
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    step();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_chan", 32'(bus.out_chan), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    push4(0, 0, 0, 0);
    frame();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
